// File: rtl/ctrl_interrupciones_pkg.sv
// rtl/ctrl_interrupciones_pkg.sv - shared types and defaults for the interrupt controller
//
// Purpose: FSM state type, default geometry of the controller and the width
// helper for the request index. Imported by codif_prioridad and
// ctrl_interrupciones.
package pkg_interrupciones;

  localparam int                N_IRQ      = 4;
  localparam int                ANCHO_DIR  = 10;
  localparam logic [9:0]        VEC_BASE   = 10'h3C0;
  localparam int                VEC_STRIDE = 4;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    PETICION = 2'd1,
    SERVICIO = 2'd2
  } estado_e;

  // Width of a request index; never below one bit so the port always exists.
  function automatic int ancho_id(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ctrl_interrupciones_codif_prioridad.sv
// rtl/ctrl_interrupciones_codif_prioridad.sv - lowest-index priority encoder
//
// Purpose: combinational fixed-priority encoder, bit 0 has highest priority.
// Ports:
//   peticiones  in   N         request vector
//   indice      out  ANCHO_ID  index of the lowest set bit (0 when none)
//   valido      out  1         at least one request bit is set
module codif_prioridad
  import pkg_interrupciones::*;
#(
  parameter int N        = 4,
  parameter int ANCHO_ID = ancho_id(N)
) (
  input  logic [N-1:0]        peticiones,
  output logic [ANCHO_ID-1:0] indice,
  output logic                valido
);

  always_comb begin
    indice = '0;
    valido = |peticiones;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (peticiones[i]) begin
        indice = ANCHO_ID'(i);
      end
    end
  end

endmodule

// File: rtl/ctrl_interrupciones.sv
// rtl/ctrl_interrupciones.sv - vectored interrupt controller for the single-cycle CPU
//
// Purpose: latches rising edges on the request lines, masks them, picks the
// lowest enabled index and asks the control unit to redirect the PC to that
// request's vector at an instruction boundary. One interrupt in service at a
// time, no nesting.
// Ports:
//   clk          in   1          system clock
//   reset        in   1          asynchronous active-low reset
//   irq_in       in   N_IRQ      request lines, rising edge raises a request
//   we_mask      in   1          load mask_in into the mask register
//   mask_in      in   N_IRQ      new mask (1 = enabled)
//   inst_fin     in   1          CPU is at an instruction boundary
//   pc_actual    in   ANCHO_DIR  address of the next instruction
//   int_ack      in   1          control unit loaded vector into the PC
//   reti         in   1          CPU executes return-from-interrupt
//   int_req      out  1          redirect request
//   vector       out  ANCHO_DIR  redirect target
//   pc_guardado  out  ANCHO_DIR  saved return address
//   int_activa   out  1          interrupt in service
//   id_activa    out  ANCHO_ID   index of the selected / serviced request
//   pendientes   out  N_IRQ      pending-request register
module ctrl_interrupciones
  import pkg_interrupciones::*;
#(
  parameter int                   N_IRQ      = pkg_interrupciones::N_IRQ,
  parameter int                   ANCHO_DIR  = pkg_interrupciones::ANCHO_DIR,
  parameter logic [ANCHO_DIR-1:0] VEC_BASE   = ANCHO_DIR'(pkg_interrupciones::VEC_BASE),
  parameter int                   VEC_STRIDE = pkg_interrupciones::VEC_STRIDE,
  localparam int                  ANCHO_ID   = ancho_id(N_IRQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_IRQ-1:0]     irq_in,
  input  logic                 we_mask,
  input  logic [N_IRQ-1:0]     mask_in,
  input  logic                 inst_fin,
  input  logic [ANCHO_DIR-1:0] pc_actual,
  input  logic                 int_ack,
  input  logic                 reti,
  output logic                 int_req,
  output logic [ANCHO_DIR-1:0] vector,
  output logic [ANCHO_DIR-1:0] pc_guardado,
  output logic                 int_activa,
  output logic [ANCHO_ID-1:0]  id_activa,
  output logic [N_IRQ-1:0]     pendientes
);

  estado_e                estado_q, estado_d;
  logic [N_IRQ-1:0]       irq_prev_q, irq_prev_d;
  logic [N_IRQ-1:0]       pend_q, pend_d;
  logic [N_IRQ-1:0]       mask_q, mask_d;
  logic [ANCHO_ID-1:0]    id_q, id_d;
  logic [ANCHO_DIR-1:0]   pc_guardado_q, pc_guardado_d;

  logic [N_IRQ-1:0]       flancos;
  logic [N_IRQ-1:0]       elegibles;
  logic [ANCHO_ID-1:0]    ganador;
  logic                   hay_elegible;

  assign flancos   = irq_in & ~irq_prev_q;
  // Only registered pending bits compete, so inputs never reach int_req
  // within the same cycle.
  assign elegibles = pend_q & mask_q;

  codif_prioridad #(
    .N        (N_IRQ),
    .ANCHO_ID (ANCHO_ID)
  ) u_codif (
    .peticiones (elegibles),
    .indice     (ganador),
    .valido     (hay_elegible)
  );

  always_comb begin
    estado_d      = estado_q;
    irq_prev_d    = irq_in;
    pend_d        = pend_q;
    mask_d        = mask_q;
    id_d          = id_q;
    pc_guardado_d = pc_guardado_q;

    if (we_mask) begin
      mask_d = mask_in;
    end

    case (estado_q)
      REPOSO: begin
        if (hay_elegible && inst_fin) begin
          id_d          = ganador;
          pc_guardado_d = pc_actual;
          estado_d      = PETICION;
        end
      end
      PETICION: begin
        // The winner is frozen here; later mask writes cannot withdraw it.
        if (int_ack) begin
          pend_d[id_q] = 1'b0;
          estado_d     = SERVICIO;
        end
      end
      SERVICIO: begin
        if (reti) begin
          estado_d = REPOSO;
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase

    // Applied after the acknowledge clear so a coincident new edge survives.
    pend_d = pend_d | flancos;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q      <= REPOSO;
      irq_prev_q    <= '0;
      pend_q        <= '0;
      mask_q        <= '0;
      id_q          <= '0;
      pc_guardado_q <= '0;
    end else begin
      estado_q      <= estado_d;
      irq_prev_q    <= irq_prev_d;
      pend_q        <= pend_d;
      mask_q        <= mask_d;
      id_q          <= id_d;
      pc_guardado_q <= pc_guardado_d;
    end
  end

  assign int_req     = (estado_q == PETICION);
  assign int_activa  = (estado_q == SERVICIO);
  assign id_activa   = id_q;
  assign pendientes  = pend_q;
  assign pc_guardado = pc_guardado_q;
  // Modulo 2^ANCHO_DIR by construction of the result width.
  assign vector      = VEC_BASE + ANCHO_DIR'(id_q) * ANCHO_DIR'(VEC_STRIDE);

endmodule

// File: tb/tb_ctrl_interrupciones.sv
// tb/tb_ctrl_interrupciones.sv - scoreboard bench for ctrl_interrupciones
module tb_ctrl_interrupciones;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       we_mask;
  logic [3:0] mask_in;
  logic       inst_fin;
  logic [9:0] pc_actual;
  logic       int_ack;
  logic       reti;
  logic       int_req;
  logic [9:0] vector;
  logic [9:0] pc_guardado;
  logic       int_activa;
  logic [1:0] id_activa;
  logic [3:0] pendientes;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  ctrl_interrupciones dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .we_mask     (we_mask),
    .mask_in     (mask_in),
    .inst_fin    (inst_fin),
    .pc_actual   (pc_actual),
    .int_ack     (int_ack),
    .reti        (reti),
    .int_req     (int_req),
    .vector      (vector),
    .pc_guardado (pc_guardado),
    .int_activa  (int_activa),
    .id_activa   (id_activa),
    .pendientes  (pendientes)
  );

  typedef struct {
    logic [9:0] vec;
    logic [9:0] pc;
    logic [1:0] id;
    logic [3:0] pend;
  } req_t;

  req_t       req_q[$];
  logic [3:0] ack_q[$];

  // Reference model: which requests are outstanding and what phase of
  // the handshake the CPU is in.
  int         m_fase;   // 0 idle, 1 waiting for ack, 2 in service
  logic [3:0] m_pend, m_mask, m_prev;
  int         m_id;

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nombre, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int menor(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Advance the model over the coming clock edge using the current inputs.
  task automatic model_step();
    logic [3:0] nuevo;
    logic [3:0] elig;
    logic [9:0] pc_cap;
    bit         pide, acepta;
    nuevo  = m_pend;
    elig   = m_pend & m_mask;
    pide   = 0;
    acepta = 0;
    pc_cap = pc_actual;
    if (m_fase == 0) begin
      if (elig != 0 && inst_fin) begin
        m_id   = menor(elig);
        m_fase = 1;
        pide   = 1;
      end
    end else if (m_fase == 1) begin
      if (int_ack) begin
        nuevo[m_id] = 1'b0;
        m_fase      = 2;
        acepta      = 1;
      end
    end else if (reti) begin
      m_fase = 0;
    end
    nuevo  = nuevo | (irq_in & ~m_prev);
    m_pend = nuevo;
    if (we_mask) m_mask = mask_in;
    m_prev = irq_in;
    if (pide) req_q.push_back('{10'h3C0 + 10'(m_id * 4), pc_cap, 2'(m_id), nuevo});
    if (acepta) ack_q.push_back(nuevo);
  endtask

  // Monitor: checks every new redirect request and every service entry
  // against what the model queued.
  initial begin
    logic pr, pa;
    req_t r;
    logic [3:0] p;
    pr = 1'b0;
    pa = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("req_y_activa", {31'd0, int_req & int_activa}, 32'd0);
        if (int_req && !pr) begin
          if (req_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_inesperado: int_req rose with vector=%0h, none expected", vector);
          end else begin
            r = req_q.pop_front();
            chk("sb_vector", 32'(vector), 32'(r.vec));
            chk("sb_pc_guardado", 32'(pc_guardado), 32'(r.pc));
            chk("sb_id_activa", 32'(id_activa), 32'(r.id));
            chk("sb_pend_req", 32'(pendientes), 32'(r.pend));
          end
        end
        if (int_activa && !pa) begin
          if (ack_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_inesperado: int_activa rose, none expected");
          end else begin
            p = ack_q.pop_front();
            chk("sb_pend_ack", 32'(pendientes), 32'(p));
          end
        end
      end
      pr = int_req;
      pa = int_activa;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; irq_in = '0; we_mask = 0; mask_in = '0; inst_fin = 0;
    pc_actual = '0; int_ack = 0; reti = 0;
    tick(); tick();
    reset = 1'b1;

    // Reset values
    chk("rst_int_req", 32'(int_req), 0);
    chk("rst_int_activa", 32'(int_activa), 0);
    chk("rst_id", 32'(id_activa), 0);
    chk("rst_pend", 32'(pendientes), 0);
    chk("rst_vector", 32'(vector), 32'h3C0);
    chk("rst_pc", 32'(pc_guardado), 0);

    // Single request on bit 2
    we_mask = 1; mask_in = 4'b1111; tick(); we_mask = 0;
    inst_fin = 1; pc_actual = 10'h025; irq_in = 4'b0100; tick();
    chk("sr_pend", 32'(pendientes), 32'b0100);
    chk("sr_req_early", 32'(int_req), 0);
    tick();
    chk("sr_req", 32'(int_req), 1);
    chk("sr_vector", 32'(vector), 32'h3C8);
    chk("sr_pc", 32'(pc_guardado), 32'h025);
    int_ack = 1; tick(); int_ack = 0;
    chk("sr_req_drop", 32'(int_req), 0);
    chk("sr_activa", 32'(int_activa), 1);
    chk("sr_pend_clr", 32'(pendientes), 0);
    reti = 1; tick(); reti = 0;
    chk("sr_reti", 32'(int_activa), 0);
    irq_in = 0; inst_fin = 0; tick();

    // Priority: bits 3 and 1 together
    irq_in = 4'b1010; tick();
    chk("pr_pend", 32'(pendientes), 32'b1010);
    inst_fin = 1; tick();
    chk("pr_id1", 32'(id_activa), 1);
    chk("pr_vec1", 32'(vector), 32'h3C4);
    reti = 1; tick(); reti = 0;
    chk("pr_reti_ignored", 32'(int_req), 1);
    int_ack = 1; tick(); int_ack = 0;
    chk("pr_pend_after", 32'(pendientes), 32'b1000);
    reti = 1; tick(); reti = 0;
    chk("pr_back_idle", 32'(int_activa | int_req), 0);
    tick();
    chk("pr_req2", 32'(int_req), 1);
    chk("pr_id3", 32'(id_activa), 3);
    chk("pr_vec3", 32'(vector), 32'h3CC);

    // Set/clear collision on the serviced bit
    irq_in = 0; tick();
    irq_in = 4'b1000; int_ack = 1; tick(); int_ack = 0;
    chk("col_activa", 32'(int_activa), 1);
    chk("col_pend", 32'(pendientes), 32'b1000);
    reti = 1; tick(); reti = 0;
    tick();
    chk("col_rereq", 32'(int_req), 1);

    // Asynchronous reset mid-PETICION
    #2 reset = 1'b0; #1;
    chk("ar_int_req", 32'(int_req), 0);
    chk("ar_pend", 32'(pendientes), 0);
    chk("ar_vector", 32'(vector), 32'h3C0);
    chk("ar_pc", 32'(pc_guardado), 0);
    irq_in = 0; inst_fin = 0; tick(); reset = 1'b1;

    // Mask: pending but disabled, then enabled
    inst_fin = 1; irq_in = 4'b0001; tick();
    chk("mk_pend", 32'(pendientes), 32'b0001);
    tick(); chk("mk_noreq_a", 32'(int_req), 0);
    tick(); chk("mk_noreq_b", 32'(int_req), 0);
    we_mask = 1; mask_in = 4'b0001; tick(); we_mask = 0;
    chk("mk_noreq_c", 32'(int_req), 0);
    tick(); chk("mk_req", 32'(int_req), 1);
    int_ack = 1; tick(); int_ack = 0;
    reti = 1; tick(); reti = 0;

    // Boundary wait
    inst_fin = 0; irq_in = 0; tick();
    irq_in = 4'b0001; tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bw_noreq", 32'(int_req), 0);
    end
    inst_fin = 1; tick();
    chk("bw_req", 32'(int_req), 1);
    we_mask = 1; mask_in = 4'b0000; tick(); we_mask = 0;
    chk("bw_mask_keeps", 32'(int_req), 1);

    // Randomized run against the model
    reset = 1'b0; irq_in = 0; we_mask = 0; inst_fin = 0; int_ack = 0; reti = 0;
    tick(); tick();
    m_fase = 0; m_pend = 0; m_mask = 0; m_prev = 0; m_id = 0;
    reset = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] t;
      for (int b = 0; b < 4; b++) t[b] = ($urandom_range(3) == 0);
      irq_in    = irq_in ^ t;
      we_mask   = ($urandom_range(15) == 0);
      mask_in   = 4'($urandom);
      inst_fin  = 1'($urandom);
      pc_actual = 10'($urandom);
      int_ack   = ($urandom_range(2) == 0);
      reti      = ($urandom_range(3) == 0);
      model_step();
      tick();
    end
    @(negedge clk);
    #1 mon_en = 1'b0;
    chk("sb_req_drained", req_q.size(), 0);
    chk("sb_ack_drained", ack_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
